// File: rtl/ahbl_arbiter_2port.sv
// Two-master to one-slave AHB-Lite arbiter: src0 (data) beats src1 (instruction),
// losers wait in a one-deep address-phase buffer, and locked sequences keep their grant.
module ahbl_arbiter_2port #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [W_ADDR-1:0] src0_haddr,
    input  logic              src0_hwrite,
    input  logic [1:0]        src0_htrans,
    input  logic [2:0]        src0_hsize,
    input  logic [2:0]        src0_hburst,
    input  logic [3:0]        src0_hprot,
    input  logic              src0_hmastlock,
    input  logic              src0_hexcl,
    input  logic [W_DATA-1:0] src0_hwdata,
    output logic              src0_hready,
    output logic              src0_hresp,
    output logic              src0_hexokay,
    output logic [W_DATA-1:0] src0_hrdata,

    input  logic [W_ADDR-1:0] src1_haddr,
    input  logic              src1_hwrite,
    input  logic [1:0]        src1_htrans,
    input  logic [2:0]        src1_hsize,
    input  logic [2:0]        src1_hburst,
    input  logic [3:0]        src1_hprot,
    input  logic              src1_hmastlock,
    input  logic              src1_hexcl,
    input  logic [W_DATA-1:0] src1_hwdata,
    output logic              src1_hready,
    output logic              src1_hresp,
    output logic              src1_hexokay,
    output logic [W_DATA-1:0] src1_hrdata,

    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic              dst_hexcl,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic              dst_hready,
    input  logic              dst_hresp,
    input  logic              dst_hexokay,
    input  logic [W_DATA-1:0] dst_hrdata
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [3:0]        prot;
        logic              mastlock;
        logic              excl;
    } addr_phase_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SRC0 = 2'd1,
        OWN_SRC1 = 2'd2
    } owner_t;

    addr_phase_t [1:0] live_ap;
    addr_phase_t [1:0] buf_q, buf_d;
    logic [1:0]        buf_valid_q, buf_valid_d;
    logic              grant_q, grant_d, grant_c;
    logic              lock_q, lock_d;
    owner_t            owner_q, owner_d;

    logic [1:0]        src_hready_c;
    logic [1:0]        req_live;
    logic [1:0]        req;
    logic              issue;
    addr_phase_t       sel_ap;

    logic              unused_inputs;
    assign unused_inputs = ^{src0_hburst, src1_hburst, src0_htrans[0], src1_htrans[0]};

    assign live_ap[0] = '{addr: src0_haddr, write: src0_hwrite, size: src0_hsize,
                          prot: src0_hprot, mastlock: src0_hmastlock, excl: src0_hexcl};
    assign live_ap[1] = '{addr: src1_haddr, write: src1_hwrite, size: src1_hsize,
                          prot: src1_hprot, mastlock: src1_hmastlock, excl: src1_hexcl};

    // Stall depends only on registered state and dst_hready, never on live htrans.
    always_comb begin
        src_hready_c[0] = (owner_q == OWN_SRC0) ? dst_hready : ~buf_valid_q[0];
        src_hready_c[1] = (owner_q == OWN_SRC1) ? dst_hready : ~buf_valid_q[1];
    end

    assign req_live[0] = rst_n & src0_htrans[1] & src_hready_c[0];
    assign req_live[1] = rst_n & src1_htrans[1] & src_hready_c[1];
    assign req         = buf_valid_q | req_live;

    // Grant moves only on a completing address phase and never away from a locked source.
    always_comb begin
        if (!dst_hready || lock_q) begin
            grant_c = grant_q;
        end else begin
            grant_c = ~req[0];
        end
    end

    assign sel_ap = buf_valid_q[grant_c] ? buf_q[grant_c] : live_ap[grant_c];
    assign issue  = req[grant_c] & dst_hready;

    assign dst_haddr     = sel_ap.addr;
    assign dst_hwrite    = sel_ap.write;
    assign dst_hsize     = sel_ap.size;
    assign dst_hprot     = sel_ap.prot;
    assign dst_hmastlock = sel_ap.mastlock;
    assign dst_hexcl     = sel_ap.excl;
    assign dst_hburst    = 3'b000;
    assign dst_htrans    = req[grant_c] ? HTRANS_NONSEQ : HTRANS_IDLE;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        grant_d     = grant_c;
        lock_d      = lock_q;
        owner_d     = owner_q;
        for (int n = 0; n < 2; n++) begin
            if (issue && (grant_c == 1'(n))) begin
                buf_valid_d[n] = 1'b0;
            end else if (req_live[n]) begin
                buf_valid_d[n] = 1'b1;
                buf_d[n]       = live_ap[n];
            end
        end
        if (dst_hready) begin
            lock_d = req[grant_c] & sel_ap.mastlock;
            if (!req[grant_c]) begin
                owner_d = OWN_NONE;
            end else begin
                owner_d = grant_c ? OWN_SRC1 : OWN_SRC0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= '0;
            buf_q       <= '0;
            grant_q     <= 1'b0;
            lock_q      <= 1'b0;
            owner_q     <= OWN_NONE;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            grant_q     <= grant_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
        end
    end

    // Data-phase routing follows the registered owner.
    always_comb begin
        dst_hwdata = '0;
        case (owner_q)
            OWN_SRC0: dst_hwdata = src0_hwdata;
            OWN_SRC1: dst_hwdata = src1_hwdata;
            default:  dst_hwdata = '0;
        endcase
    end

    assign src0_hready  = src_hready_c[0];
    assign src1_hready  = src_hready_c[1];
    assign src0_hresp   = (owner_q == OWN_SRC0) & dst_hresp;
    assign src1_hresp   = (owner_q == OWN_SRC1) & dst_hresp;
    assign src0_hexokay = (owner_q == OWN_SRC0) & dst_hexokay;
    assign src1_hexokay = (owner_q == OWN_SRC1) & dst_hexokay;
    assign src0_hrdata  = dst_hrdata;
    assign src1_hrdata  = dst_hrdata;

endmodule
